// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin byte arbiter driving a UART over Wishbone
// Define UART_ARB_TIMEOUT_EN to add the ack watchdog and the sticky err_o flag.
module uart_tx_arbiter #(
  parameter int          N_REQ       = 4,
  parameter logic [31:0] BASE_ADR    = 32'h2000_0000,
  parameter logic [7:0]  CLK_DIV_OFF = 8'h00,
  parameter logic [7:0]  DATA_OFF    = 8'h04,
  parameter logic [7:0]  CONFIG_OFF  = 8'h08,
  parameter logic [31:0] INIT_DIV    = 32'd104,
  parameter logic [15:0] TIMEOUT_CYC = 16'd4096
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [31:0]        wbm_adr_o,
  output logic [31:0]        wbm_dat_o,
  output logic [3:0]         wbm_sel_o,
  output logic               wbm_we_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  input  logic               wbm_ack_i,
  output logic [2:0]         grant_o,
  output logic               busy_o,
  output logic               init_done_o
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic               err_o
`endif
);

  typedef enum logic [2:0] {INIT_DIV_ST, INIT_CFG_ST, IDLE_ST, XFER_ST, GAP_ST} state_t;

  state_t      state_q, state_d, ret_q, ret_d;
  logic [2:0]  grant_q, grant_d, last_q, last_d;
  logic [7:0]  byte_q, byte_d;
  logic        done_q, done_d;
  logic        stb_q, stb_d;
  logic [31:0] adr_q, adr_d, dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        ack_v, tmo;
  logic        found;
  int          idx, pick;

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC == 16'd0) begin : g_param_check
    $error("uart_tx_arbiter: parameter out of range");
  end

  // Ack only counts while our strobe is actually out on the bus.
  assign ack_v = wbm_ack_i & stb_q;

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic        err_q;
  assign tmo   = stb_q & ~wbm_ack_i & (cnt_q == TIMEOUT_CYC - 16'd1);
  assign err_o = err_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= stb_q ? cnt_q + 16'd1 : 16'd0;
      if (tmo) err_q <= 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    found = 1'b0;
    pick  = 0;
    idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    grant_d     = grant_q;
    last_d      = last_q;
    byte_d      = byte_q;
    done_d      = done_q;
    req_ready_o = '0;
    case (state_q)
      INIT_DIV_ST: begin
        if (ack_v) begin
          state_d = GAP_ST;
          ret_d   = INIT_CFG_ST;
        end else if (tmo) begin
          state_d = GAP_ST;
          ret_d   = INIT_DIV_ST;
        end
      end
      INIT_CFG_ST: begin
        if (ack_v) begin
          state_d = GAP_ST;
          ret_d   = IDLE_ST;
          done_d  = 1'b1;
        end else if (tmo) begin
          state_d = GAP_ST;
          ret_d   = INIT_CFG_ST;
        end
      end
      IDLE_ST: begin
        if (found) begin
          grant_d = 3'(pick);
          byte_d  = req_data_i[8*pick +: 8];
          state_d = XFER_ST;
        end
      end
      XFER_ST: begin
        if (ack_v) begin
          req_ready_o = {{(N_REQ-1){1'b0}}, 1'b1} << grant_q;
          last_d      = grant_q;
          state_d     = GAP_ST;
          ret_d       = IDLE_ST;
        end else if (tmo) begin
          last_d  = grant_q;
          state_d = GAP_ST;
          ret_d   = IDLE_ST;
        end
      end
      GAP_ST:  state_d = ret_q;
      default: state_d = INIT_DIV_ST;
    endcase

    // Bus outputs are registered from the next state, so ack never reaches stb combinationally.
    stb_d = 1'b0;
    adr_d = '0;
    dat_d = '0;
    sel_d = '0;
    case (state_d)
      INIT_DIV_ST: begin
        stb_d = 1'b1;
        adr_d = BASE_ADR | {24'h0, CLK_DIV_OFF};
        dat_d = INIT_DIV;
        sel_d = 4'hF;
      end
      INIT_CFG_ST: begin
        stb_d = 1'b1;
        adr_d = BASE_ADR | {24'h0, CONFIG_OFF};
        dat_d = 32'h1;
        sel_d = 4'h1;
      end
      XFER_ST: begin
        stb_d = 1'b1;
        adr_d = BASE_ADR | {24'h0, DATA_OFF};
        dat_d = {24'h0, byte_d};
        sel_d = 4'h1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= INIT_DIV_ST;
      ret_q   <= INIT_DIV_ST;
      grant_q <= '0;
      last_q  <= 3'(N_REQ - 1);
      byte_q  <= '0;
      done_q  <= 1'b0;
      stb_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      byte_q  <= byte_d;
      done_q  <= done_d;
      stb_q   <= stb_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
    end
  end

  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_we_o    = stb_q;
  assign wbm_cyc_o   = stb_q;
  assign wbm_stb_o   = stb_q;
  assign busy_o      = stb_q;
  assign grant_o     = grant_q;
  assign init_done_o = done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed table and sequence checks for uart_tx_arbiter
// Optional UART_ARB_TIMEOUT_EN section exercises the ack watchdog.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  valid = '0;
  logic [31:0] data = '0;
  logic        ack_en = 1'b0;
  logic [3:0]  ready;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic        we, cyc, stb, ack, busy, done;
  logic [2:0]  grant;
`ifdef UART_ARB_TIMEOUT_EN
  logic        err;
`endif

  int errors = 0;
  int checks = 0;
  int cycle_cnt = 0;
  int ready_cnt = 0;

  assign ack = stb & ack_en;

  uart_tx_arbiter #(.N_REQ(4), .TIMEOUT_CYC(16'd16)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .req_valid_i (valid),
    .req_data_i  (data),
    .req_ready_o (ready),
    .wbm_adr_o   (adr),
    .wbm_dat_o   (dat),
    .wbm_sel_o   (sel),
    .wbm_we_o    (we),
    .wbm_cyc_o   (cyc),
    .wbm_stb_o   (stb),
    .wbm_ack_i   (ack),
    .grant_o     (grant),
    .busy_o      (busy),
    .init_done_o (done)
`ifdef UART_ARB_TIMEOUT_EN
    ,
    .err_o       (err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;
  always @(negedge clk) if (|ready) ready_cnt <= ready_cnt + 1;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic        stb;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [3:0]  ready;
    logic [2:0]  grant;
    logic        done;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_stb(input string name);
    int n = 0;
    while (!stb && n < 8) begin
      step();
      n++;
    end
    chk({name, "_stb_timeout"}, {95'h0, stb}, 96'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int last_pulse;
    int n;
    int base_rdy;
    int exp_order[6];

    vecs[0] = '{4'h0, 32'h0,         1'b0, 32'h0,         32'h0,  4'h0, 4'h0, 3'd0, 1'b0};
    vecs[1] = '{4'h0, 32'h0,         1'b1, 32'h2000_0000, 32'h68, 4'hF, 4'h0, 3'd0, 1'b0};
    vecs[2] = '{4'h0, 32'h0,         1'b0, 32'h0,         32'h0,  4'h0, 4'h0, 3'd0, 1'b0};
    vecs[3] = '{4'h0, 32'h0,         1'b1, 32'h2000_0008, 32'h1,  4'h1, 4'h0, 3'd0, 1'b0};
    vecs[4] = '{4'h0, 32'h0,         1'b0, 32'h0,         32'h0,  4'h0, 4'h0, 3'd0, 1'b1};
    vecs[5] = '{4'h4, 32'h00A5_0000, 1'b0, 32'h0,         32'h0,  4'h0, 4'h0, 3'd0, 1'b1};
    vecs[6] = '{4'h4, 32'h00A5_0000, 1'b1, 32'h2000_0004, 32'hA5, 4'h1, 4'h4, 3'd2, 1'b1};
    vecs[7] = '{4'h0, 32'h00A5_0000, 1'b0, 32'h0,         32'h0,  4'h0, 4'h0, 3'd2, 1'b1};
    vecs[8] = '{4'h0, 32'h00A5_0000, 1'b0, 32'h0,         32'h0,  4'h0, 4'h0, 3'd2, 1'b1};

    repeat (3) step();
    chk("reset_outputs", {47'h0, cyc, stb, we, busy, done, ready, grant, adr, sel},
        {47'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 3'd0, 32'h0, 4'h0});
`ifdef UART_ARB_TIMEOUT_EN
    chk("reset_err", {95'h0, err}, 96'h0);
`endif
    rst = 1'b0;
    ack_en = 1'b1;

    for (int i = 0; i < 9; i++) begin
      valid = vecs[i].valid;
      data  = vecs[i].data;
      #1;
      chk($sformatf("vec%0d", i),
          {13'h0, cyc, stb, we, adr, dat, sel, ready, grant, done},
          {13'h0, vecs[i].stb, vecs[i].stb, vecs[i].stb, vecs[i].adr, vecs[i].dat,
           vecs[i].sel, vecs[i].ready, vecs[i].grant, vecs[i].done});
      step();
    end

    // All four continuously valid; the A5 write left the pointer at 2.
    exp_order = '{3, 0, 1, 2, 3, 0};
    valid = 4'hF;
    data  = 32'h4332_2110;
    last_pulse = 0;
    for (int b = 0; b < 6; b++) begin
      n = 0;
      while (ready == 4'h0 && n < 8) begin
        step();
        n++;
      end
      chk($sformatf("rr%0d_ready", b), {92'h0, ready}, {92'h0, 4'(1 << exp_order[b])});
      chk($sformatf("rr%0d_grant", b), {93'h0, grant}, {93'h0, 3'(exp_order[b])});
      chk($sformatf("rr%0d_dat", b), {64'h0, dat}, {64'h0, 24'h0, data[8*exp_order[b] +: 8]});
      if (b > 0) chk($sformatf("rr%0d_latency", b), 96'(cycle_cnt - last_pulse), 96'd3);
      last_pulse = cycle_cnt;
      step();
    end
    valid = 4'h0;
    step();

    // Slave stalls ack for 50 cycles; pointer is at 0 so requester 1 wins.
    ack_en = 1'b0;
    valid  = 4'hF;
    wait_stb("stall");
    base_rdy = ready_cnt;
    for (int i = 0; i < 50; i++) begin
      chk($sformatf("stall_hold%0d", i), {27'h0, stb, adr, dat, ready},
          {27'h0, 1'b1, 32'h2000_0004, 32'h21, 4'h0});
      step();
    end
    ack_en = 1'b1;
    #1;
    chk("stall_release", {89'h0, ready, grant}, {89'h0, 4'b0010, 3'd1});
    step();
    chk("stall_stb_drop", {95'h0, stb}, 96'h0);
    chk("stall_one_pulse", 96'(ready_cnt - base_rdy), 96'd1);

    // Asynchronous reset in the middle of a stalled data write.
    ack_en = 1'b0;
    valid  = 4'b0100;
    wait_stb("rst_xfer");
    chk("rst_xfer_grant", {93'h0, grant}, {93'h0, 3'd2});
    base_rdy = ready_cnt;
    rst = 1'b1;
    #1;
    chk("rst_async", {91'h0, cyc, stb, ready}, 96'h0);
    step();
    step();
    chk("rst_done_clear", {95'h0, done}, 96'h0);
    rst = 1'b0;
    valid = 4'h0;
    ack_en = 1'b1;
    wait_stb("reinit_div");
    chk("reinit_div", {28'h0, adr, dat, sel}, {28'h0, 32'h2000_0000, 32'h68, 4'hF});
    step();
    chk("reinit_gap", {95'h0, stb}, 96'h0);
    wait_stb("reinit_cfg");
    chk("reinit_cfg", {28'h0, adr, dat, sel}, {28'h0, 32'h2000_0008, 32'h1, 4'h1});
    step();
    chk("reinit_done", {95'h0, done}, 96'h1);
    chk("rst_no_pulse", 96'(ready_cnt - base_rdy), 96'd0);
    step();

`ifdef UART_ARB_TIMEOUT_EN
    // Ack never comes: watchdog drops the write, pointer advances past requester 0.
    ack_en = 1'b0;
    valid  = 4'b0011;
    data   = 32'h0000_BB11;
    base_rdy = ready_cnt;
    wait_stb("tmo");
    chk("tmo_grant", {93'h0, grant}, {93'h0, 3'd0});
    n = 0;
    while (stb && n < 40) begin
      step();
      n++;
    end
    chk("tmo_len", 96'(n), 96'd16);
    chk("tmo_err", {95'h0, err}, 96'h1);
    chk("tmo_no_pulse", 96'(ready_cnt - base_rdy), 96'd0);
    ack_en = 1'b1;
    n = 0;
    while (ready == 4'h0 && n < 8) begin
      step();
      n++;
    end
    chk("tmo_next", {89'h0, ready, grant}, {89'h0, 4'b0010, 3'd1});
    step();
    chk("tmo_err_sticky", {95'h0, err}, 96'h1);
    valid = 4'h0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
